// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states,
// iteration-engine modes and the packed flag bundle carried with each result.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_DIV = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef struct packed {
    logic carry;
    logic zero;
    logic div_by_zero;
    logic illegal_op;
  } flags_t;

  // Legal opcodes occupy the contiguous range ADD..XOR.
  function automatic logic op_legal(input logic [3:0] code);
    return code <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative engine: shift-add multiply (LSB first) or restoring divide
// (MSB first), one bit per cycle. The counter saturates, so results hold until restarted.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  // hi holds the partial-product upper half or the running remainder;
  // lo holds the multiplier being shifted out or the dividend/quotient.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic             mode_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_geq;
  logic [WIDTH-1:0] div_sub;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_geq   = div_shift >= {1'b0, opnd_q};
    // Modular subtract is exact here: when div_geq holds the true difference is below the divisor.
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      mode_q  <= MODE_MUL;
      count_q <= '0;
    end else if (start) begin
      hi_q    <= '0;
      lo_q    <= a;
      opnd_q  <= b;
      mode_q  <= mode;
      count_q <= '0;
    end else if (count_q != LAST) begin
      count_q <= count_q + 1'b1;
      if (mode_q == MODE_DIV) begin
        hi_q <= div_geq ? div_sub : div_shift[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], div_geq};
      end else begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  assign done    = (count_q == LAST);
  assign product = {hi_q, lo_q};

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic, iterative mul/div through
// alu_seq_iter, and a registered result slot that stalls under back-pressure.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  state_e           state_q;
  state_e           state_d;

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  flags_t           flags_q;
  logic             out_valid_q;

  logic             load;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] hi_d;
  flags_t           flags_d;

  logic             eng_start;
  logic             eng_mode;
  logic             eng_done;
  logic [2*WIDTH-1:0] eng_out;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;

  logic             slot_free;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // The slot is free when empty or being drained on this very edge.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  // The extra MSB is carry-out for ADD and borrow (a < b) for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  assign eng_lo = eng_out[WIDTH-1:0];
  assign eng_hi = eng_out[2*WIDTH-1:WIDTH];

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clock   (clock),
    .reset   (reset),
    .start   (eng_start),
    .mode    (eng_mode),
    .a       (a),
    .b       (b),
    .done    (eng_done),
    .product (eng_out)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    eng_start = 1'b0;
    eng_mode  = MODE_MUL;
    res_d     = '0;
    hi_d      = '0;
    flags_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!op_legal(op)) begin
            load               = 1'b1;
            res_d              = '1;
            flags_d.illegal_op = 1'b1;
          end else begin
            case (op)
              OP_ADD: begin
                load          = 1'b1;
                res_d         = sum[WIDTH-1:0];
                flags_d.carry = sum[WIDTH];
              end
              OP_SUB: begin
                load          = 1'b1;
                res_d         = diff[WIDTH-1:0];
                flags_d.carry = diff[WIDTH];
              end
              OP_AND: begin
                load  = 1'b1;
                res_d = a & b;
              end
              OP_OR: begin
                load  = 1'b1;
                res_d = a | b;
              end
              OP_XOR: begin
                load  = 1'b1;
                res_d = a ^ b;
              end
              OP_MUL: begin
                eng_start = 1'b1;
                eng_mode  = MODE_MUL;
                state_d   = S_MUL;
              end
              OP_DIV: begin
                if (b == '0) begin
                  load                = 1'b1;
                  res_d               = '1;
                  hi_d                = a;
                  flags_d.div_by_zero = 1'b1;
                end else begin
                  eng_start = 1'b1;
                  eng_mode  = MODE_DIV;
                  state_d   = S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
      end

      // Completion waits here with the engine saturated until the slot frees.
      S_MUL: begin
        if (eng_done && slot_free) begin
          load          = 1'b1;
          res_d         = eng_lo;
          hi_d          = eng_hi;
          flags_d.carry = |eng_hi;
          state_d       = S_IDLE;
        end
      end

      S_DIV: begin
        if (eng_done && slot_free) begin
          load    = 1'b1;
          res_d   = eng_lo;
          hi_d    = eng_hi;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    flags_d.zero = (res_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      result_q    <= res_d;
      result_hi_q <= hi_d;
      flags_q     <= flags_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign carry       = flags_q.carry;
  assign zero        = flags_q.zero;
  assign div_by_zero = flags_q.div_by_zero;
  assign illegal_op  = flags_q.illegal_op;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): vector table with latency checks,
// a model-fed scoreboard on both handshakes, and hand-written stall/reset sequences.
module tb_alu_seq;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         div_by_zero;
  logic         illegal_op;

  alu_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .carry       (carry),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clock = ~clock;

  // Flag order: carry, zero, div_by_zero, illegal_op.
  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] flags;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    exp_t       e;
    int         extra;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  exp_t sb[$];
  exp_t act;
  vec_t vecs[15];

  assign act = {result, result_hi, carry, zero, div_by_zero, illegal_op};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, got, want);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] code);
    exp_t        e;
    int unsigned p;
    e = '0;
    p = 0;
    case (code)
      4'h0: begin p = x + y; e.res = p[7:0]; e.flags[3] = p[8]; end
      4'h1: begin e.res = 8'(x - y); e.flags[3] = (x < y); end
      4'h2: begin p = x * y; e.res = p[7:0]; e.hi = p[15:8]; e.flags[3] = (p[15:8] != 0); end
      4'h3: begin
        if (y == 0) begin e.res = 8'hFF; e.hi = x; e.flags[1] = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; end
      end
      4'h4: e.res = x & y;
      4'h5: e.res = x | y;
      4'h6: e.res = x ^ y;
      default: begin e.res = 8'hFF; e.flags[0] = 1'b1; end
    endcase
    e.flags[2] = (e.res == 0);
    return e;
  endfunction

  function automatic vec_t mkv(input logic [7:0] x, input logic [7:0] y, input logic [3:0] code,
                               input logic [7:0] r, input logic [7:0] h, input logic [3:0] f,
                               input int extra);
    return {x, y, code, r, h, f, extra};
  endfunction

  // Scoreboard: model pushed on input handshake, popped on output handshake.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
        else                check("sb_result", 32'(act), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready) begin
        n_in++;
        sb.push_back(model(a, b, op));
      end
    end
  end

  // extra = edges after the accepting edge before out_valid is observed.
  task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] code, input exp_t e, input int extra);
    int edges;
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a  = x;
    b  = y;
    op = code;
    @(negedge clock);
    check({name, "_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    edges = 0;
    @(negedge clock);
    while (!out_valid && edges < 40) begin
      check({name, "_busy"}, 32'(in_ready), 32'd0);
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    check({name, "_lat"}, 32'(edges), 32'(extra));
    check({name, "_out"}, 32'(act), 32'(e));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    int   n1;
    int   waited;
    exp_t held;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a  = '0;
    b  = '0;
    op = '0;

    //           a      b      op    res    hi     cz d i  extra
    vecs[0]  = mkv(8'hF0, 8'h20, 4'h0, 8'h10, 8'h00, 4'b1000, 0);
    vecs[1]  = mkv(8'h05, 8'h05, 4'h1, 8'h00, 8'h00, 4'b0100, 0);
    vecs[2]  = mkv(8'hFF, 8'hFF, 4'h2, 8'h01, 8'hFE, 4'b1000, 9);
    vecs[3]  = mkv(8'd200, 8'd7, 4'h3, 8'd28,  8'd4,  4'b0000, 9);
    vecs[4]  = mkv(8'h33, 8'h00, 4'h3, 8'hFF, 8'h33, 4'b0010, 0);
    vecs[5]  = mkv(8'h12, 8'h34, 4'hF, 8'hFF, 8'h00, 4'b0001, 0);
    vecs[6]  = mkv(8'h01, 8'h01, 4'h0, 8'h02, 8'h00, 4'b0000, 0);
    vecs[7]  = mkv(8'h03, 8'h05, 4'h1, 8'hFE, 8'h00, 4'b1000, 0);
    vecs[8]  = mkv(8'hF0, 8'h3C, 4'h4, 8'h30, 8'h00, 4'b0000, 0);
    vecs[9]  = mkv(8'hF0, 8'h0F, 4'h5, 8'hFF, 8'h00, 4'b0000, 0);
    vecs[10] = mkv(8'hAA, 8'hAA, 4'h6, 8'h00, 8'h00, 4'b0100, 0);
    vecs[11] = mkv(8'h00, 8'h37, 4'h2, 8'h00, 8'h00, 4'b0100, 9);
    vecs[12] = mkv(8'h07, 8'hC8, 4'h3, 8'h00, 8'h07, 4'b0100, 9);
    vecs[13] = mkv(8'hFF, 8'h01, 4'h3, 8'hFF, 8'h00, 4'b0000, 9);
    vecs[14] = mkv(8'h10, 8'h20, 4'h7, 8'hFF, 8'h00, 4'b0001, 0);

    #1;
    check("rst_outputs", 32'({out_valid, act}), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e, vecs[i].extra);

    // Illegal op immediately followed by ADD 1+1: flags must not leak across results.
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = 4'hF; a = 8'h12; b = 8'h34;
    @(negedge clock);
    check("b2b_ready_ill", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    op = 4'h0; a = 8'h01; b = 8'h01;
    @(negedge clock);
    check("b2b_ill", 32'({out_valid, result, illegal_op}), 32'({1'b1, 8'hFF, 1'b1}));
    check("b2b_ready_add", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("b2b_add", 32'({out_valid, result, illegal_op}), 32'({1'b1, 8'h02, 1'b0}));

    // Sixteen back-to-back logic ops at full throughput.
    @(posedge clock); #1;
    n0 = n_out;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      op = 4'(4 + $urandom_range(0, 2));
      a  = 8'($urandom);
      b  = 8'($urandom);
      @(negedge clock);
      check("tput_ready", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    check("tput_count", 32'(n_out - n0), 32'd16);

    // Back-pressure: MUL 0x12*0x34 = 0x03A8 held for 5 cycles, ADD 9+9 offered meanwhile.
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 4'h2; a = 8'h12; b = 8'h34;
    @(posedge clock); #1;
    op = 4'h0; a = 8'h09; b = 8'h09;
    n1 = n_in;
    waited = 0;
    @(negedge clock);
    while (!out_valid && waited < 40) begin
      check("bp_busy", 32'(in_ready), 32'd0);
      @(posedge clock);
      waited++;
      @(negedge clock);
    end
    check("bp_lat", 32'(waited), 32'd9);
    held = {8'hA8, 8'h03, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("bp_hold", 32'({out_valid, act}), 32'({1'b1, held}));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_no_accept", 32'(n_in - n1), 32'd0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("bp_next", 32'({out_valid, result}), 32'({1'b1, 8'd18}));
    check("bp_one_accept", 32'(n_in - n1), 32'd1);

    // Reset asserted during DIV iteration 4 must clear outputs asynchronously.
    @(posedge clock); #1;
    in_valid = 1'b1;
    op = 4'h3; a = 8'd200; b = 8'd7;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_outs", 32'({out_valid, act}), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    run_op("post_rst_add", 8'd3, 8'd4, 4'h0, {8'd7, 8'd0, 4'b0000}, 0);

    @(posedge clock); #1;
    @(negedge clock);
    @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit datapath ALU. Accepts one operation per transaction on a valid/ready input, executes add/sub/logic in one cycle and multiply/divide iteratively (one bit per cycle), and returns a registered result with flags on a valid/ready output. Sits between the instruction issue stage and the writeback buffer; stalls cleanly under output back-pressure.

## Interface

- WIDTH, 8, operand and result width (≥2)

- clock  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- op  in  4  opcode: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR; others illegal
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- result  out  WIDTH  ADD/SUB/logic result; MUL low half; DIV quotient
- result_hi  out  WIDTH  MUL high half; DIV remainder; 0 otherwise
- carry  out  1  ADD carry-out; SUB borrow (a<b); MUL 1 if result_hi≠0; else 0
- zero  out  1  result==0 (result field only)
- div_by_zero  out  1  DIV with b==0
- illegal_op  out  1  opcode not in table

## Operation

- States: IDLE, MUL, DIV. Output register (result, result_hi, flags, out_valid) is separate from FSM state.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept in IDLE:
  - ADD/SUB/AND/OR/XOR/illegal: output register loaded same edge; state stays IDLE.
  - MUL: latch a, b; clear accumulator; counter=0; go MUL.
  - DIV, b≠0: latch operands; remainder=0; counter=0; go DIV.
  - DIV, b==0: load immediately: result all ones, result_hi=a, div_by_zero=1, carry=0.
  - illegal: result all ones, result_hi=0, illegal_op=1, other flags 0.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit product. After WIDTH iterations, load output register, return to IDLE.
- DIV: restoring division, one quotient bit per cycle (MSB first). After WIDTH iterations, load quotient/remainder, return to IDLE.
- Arithmetic: ADD/SUB computed at WIDTH+1 bits, result truncated to WIDTH (mod 2^WIDTH); MSB of the WIDTH+1 sum is carry/borrow.
- Output held stable while out_valid && !out_ready. out_valid cleared on consumption unless new result loaded same edge.
- MUL/DIV completion while output still held: FSM waits in final iteration (counter saturated) until output slot frees, then loads. No result dropped or overwritten.
- Flags reflect only the result they accompany.

## Timing

- Reset: state IDLE, out_valid 0, result 0, result_hi 0, all flags 0, counter 0; in_ready 1 one cycle after deassertion (combinational from state).
- Single-cycle ops: out_valid high the edge after acceptance; back-to-back throughput 1/cycle with out_ready held high.
- MUL, DIV (b≠0): out_valid high WIDTH+1 edges after acceptance edge; in_ready low throughout.
- DIV by zero: latency 1, as single-cycle ops.
- Reset mid-operation: aborts iteration, discards held result, all outputs to reset values asynchronously.
- in_valid with in_ready low: no effect; inputs need not be held stable by this block's contract (upstream holds per standard valid/ready).

## Structure

- Package alu_seq_pkg: opcode enum (op_e), FSM state enum, opcode-legality function.
- Sub-module alu_seq_iter: shared iterative multiply/divide engine (start, mode, operands, done, 2·WIDTH output); top holds FSM control, single-cycle datapath, output register.
- Counter width $clog2(WIDTH+1).

## Test plan

- WIDTH=8, ADD a=0xF0 b=0x20, out_ready=1 -> next cycle result=0x10, carry=1, zero=0; SUB a=0x05 b=0x05 -> result=0x00, zero=1, carry=0.
- MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, result=0x01, result_hi=0xFE, carry=1; in_ready low during iteration.
- DIV a=200 b=7 -> result=28, result_hi=4 after 9 cycles; DIV a=0x33 b=0 -> next cycle result=0xFF, result_hi=0x33, div_by_zero=1.
- op=1111 -> result=0xFF, illegal_op=1; then ADD 1+1 back-to-back -> result=2, illegal_op=0; throughput 1/cycle over 16 random logic ops checked against model.
- Back-pressure: out_ready=0 for 5 cycles after MUL completes -> result stable, in_ready=0, no second accept; out_ready=1 -> one handshake, in_ready rises same cycle.
- Assert reset during DIV iteration 4 -> all outputs 0 immediately, state IDLE, subsequent ADD 3+4 returns 7.
